// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared state encoding, BCD constants and digit clamp for the countdown timer
package game_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit decrementer, 0 wraps to 9 and raises a borrow to the next digit
module bcd_digit_dec
  import game_timer_pkg::*;
(
  input  logic [3:0] d,
  input  logic       en,
  output logic [3:0] q,
  output logic       borrow_out
);
  assign borrow_out = en && (d == BCD_ZERO);
  assign q = !en ? d : (d == BCD_ZERO) ? BCD_NINE : d - 4'd1;
endmodule

// File: rtl/game_countdown_timer.sv
// game_countdown_timer: BCD ss.t round timer driven by a 100 ms tick, with run/pause/expire control
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter logic [7:0] DEFAULT_SEC = 8'h30,
  parameter logic [7:0] WARN_SEC    = 8'h05
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_sec,
  input  logic [3:0] load_tenths,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       warn,
  output logic       expired,
  output logic       expire_pulse
);
  state_t state, nextState;
  logic [3:0] nextTens, nextOnes, nextTenths;
  logic [3:0] decTens, decOnes, decTenths;
  logic borrowTenths, borrowOnes, borrowTens;
  logic nextPulse, decEn, atOne, isZero;
  assign decEn  = tick_100ms && (state == RUN);
  assign atOne  = {sec_tens, sec_ones, tenths} == 12'h001;
  assign isZero = {sec_tens, sec_ones, tenths} == 12'h000;
  bcd_digit_dec uTenths (.d(tenths),   .en(decEn),        .q(decTenths), .borrow_out(borrowTenths));
  bcd_digit_dec uOnes   (.d(sec_ones), .en(borrowTenths), .q(decOnes),   .borrow_out(borrowOnes));
  bcd_digit_dec uTens   (.d(sec_tens), .en(borrowOnes),   .q(decTens),   .borrow_out(borrowTens));
  always_comb begin
    nextState  = state;
    nextTens   = sec_tens;
    nextOnes   = sec_ones;
    nextTenths = tenths;
    nextPulse  = 1'b0;
    if (clear) begin
      nextState  = IDLE;
      nextTens   = DEFAULT_SEC[7:4];
      nextOnes   = DEFAULT_SEC[3:0];
      nextTenths = BCD_ZERO;
    end else if (load) begin
      nextState  = IDLE;
      nextTens   = bcd_clamp(load_sec[7:4]);
      nextOnes   = bcd_clamp(load_sec[3:0]);
      nextTenths = bcd_clamp(load_tenths);
    end else if (state == RUN && pause) begin
      nextState = PAUSED;
    end else if (state == PAUSED && start) begin
      nextState = RUN;
    end else if (state == IDLE && start && !isZero) begin
      nextState = RUN;
    end else if (decEn && !borrowTens) begin
      nextTens   = decTens;
      nextOnes   = decOnes;
      nextTenths = decTenths;
      nextState  = atOne ? EXPIRED : state;
      nextPulse  = atOne;
    end
  end
  // flags are derived from next-state values so they stay aligned with the displayed time
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sec_tens     <= DEFAULT_SEC[7:4];
      sec_ones     <= DEFAULT_SEC[3:0];
      tenths       <= BCD_ZERO;
      running      <= 1'b0;
      warn         <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      state        <= nextState;
      sec_tens     <= nextTens;
      sec_ones     <= nextOnes;
      tenths       <= nextTenths;
      running      <= nextState == RUN;
      warn         <= (nextState == RUN) && ({nextTens, nextOnes} < WARN_SEC);
      expired      <= nextState == EXPIRED;
      expire_pulse <= nextPulse;
    end
  end
endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer: directed self-checking bench for the countdown timer
module tb_game_countdown_timer;
  logic clk = 1'b0;
  logic rst, tick_100ms, clear, load, start, pause;
  logic [7:0] load_sec;
  logic [3:0] load_tenths;
  logic [3:0] sec_tens, sec_ones, tenths;
  logic running, warn, expired, expire_pulse;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  always #5 clk = ~clk;
  game_countdown_timer dut (
    .clk(clk), .rst(rst), .tick_100ms(tick_100ms), .clear(clear), .load(load),
    .load_sec(load_sec), .load_tenths(load_tenths), .start(start), .pause(pause),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .tenths(tenths), .running(running),
    .warn(warn), .expired(expired), .expire_pulse(expire_pulse)
  );
  function automatic logic [11:0] toBcd(input int ds);
    return {4'(ds / 100), 4'((ds / 10) % 10), 4'(ds % 10)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    if (expire_pulse) pulses++;
    tick_100ms = 0; clear = 0; load = 0; start = 0; pause = 0;
  endtask
  task automatic doLoad(input logic [7:0] s, input logic [3:0] t);
    load = 1; load_sec = s; load_tenths = t;
    step();
  endtask
  task automatic test_reset();
    rst = 0;
    step(); step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h300) begin errors++; $display("FAIL reset_time got %h want 300", {sec_tens, sec_ones, tenths}); end
    checks++;
    if ({running, warn, expired, expire_pulse} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {running, warn, expired, expire_pulse}); end
    rst = 1;
    for (int i = 0; i < 300; i++) begin tick_100ms = 1; step(); end
    checks++;
    if ({sec_tens, sec_ones, tenths, running} !== 13'h600) begin errors++; $display("FAIL idle_ticks got %h run %b want 300 run 0", {sec_tens, sec_ones, tenths}, running); end
  endtask
  task automatic test_expire();
    int p0;
    doLoad(8'h01, 4'h2);
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h012 || running !== 1'b0) begin errors++; $display("FAIL load_012 got %h run %b want 012 run 0", {sec_tens, sec_ones, tenths}, running); end
    start = 1; step();
    checks++;
    if (running !== 1'b1 || warn !== 1'b1) begin errors++; $display("FAIL start_run got run %b warn %b want 1 1", running, warn); end
    p0 = pulses;
    for (int i = 1; i <= 12; i++) begin
      tick_100ms = 1; step();
      checks++;
      if ({sec_tens, sec_ones, tenths} !== toBcd(12 - i)) begin errors++; $display("FAIL countdown_%0d got %h want %h", i, {sec_tens, sec_ones, tenths}, toBcd(12 - i)); end
    end
    checks++;
    if ({expired, expire_pulse, running, warn} !== 4'b1100) begin errors++; $display("FAIL expire_edge got %b want 1100", {expired, expire_pulse, running, warn}); end
    step();
    checks++;
    if ({expired, expire_pulse} !== 2'b10) begin errors++; $display("FAIL expire_after got %b want 10", {expired, expire_pulse}); end
    for (int i = 0; i < 3; i++) begin tick_100ms = 1; step(); end
    start = 1; step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h000 || running !== 1'b0 || expired !== 1'b1) begin errors++; $display("FAIL expired_hold got %h run %b exp %b want 000 0 1", {sec_tens, sec_ones, tenths}, running, expired); end
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL pulse_count got %0d want 1", pulses - p0); end
  endtask
  task automatic test_borrow();
    doLoad(8'h10, 4'h0);
    checks++;
    if (expired !== 1'b0) begin errors++; $display("FAIL load_leaves_expired got %b want 0", expired); end
    start = 1; step();
    for (int k = 1; k <= 51; k++) begin
      tick_100ms = 1; step();
      checks++;
      if ({sec_tens, sec_ones, tenths} !== toBcd(100 - k) || warn !== ((100 - k) < 50)) begin
        errors++; $display("FAIL borrow_%0d got %h warn %b want %h warn %b", k, {sec_tens, sec_ones, tenths}, warn, toBcd(100 - k), (100 - k) < 50);
      end
    end
  endtask
  task automatic test_pause();
    pause = 1; tick_100ms = 1; step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h049 || running !== 1'b0 || warn !== 1'b0) begin errors++; $display("FAIL pause_tick got %h run %b warn %b want 049 0 0", {sec_tens, sec_ones, tenths}, running, warn); end
    for (int i = 0; i < 5; i++) begin tick_100ms = 1; step(); end
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h049) begin errors++; $display("FAIL paused_ticks got %h want 049", {sec_tens, sec_ones, tenths}); end
    start = 1; tick_100ms = 1; step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h049 || running !== 1'b1) begin errors++; $display("FAIL resume got %h run %b want 049 1", {sec_tens, sec_ones, tenths}, running); end
    tick_100ms = 1; step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h048) begin errors++; $display("FAIL resume_tick got %h want 048", {sec_tens, sec_ones, tenths}); end
  endtask
  task automatic test_edges();
    int p0;
    doLoad(8'hAF, 4'hC);
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h999 || running !== 1'b0) begin errors++; $display("FAIL clamp got %h run %b want 999 0", {sec_tens, sec_ones, tenths}, running); end
    doLoad(8'h00, 4'h0);
    start = 1; step();
    checks++;
    if ({running, expired} !== 2'b00) begin errors++; $display("FAIL start_zero got %b want 00", {running, expired}); end
    doLoad(8'h05, 4'h0);
    start = 1; step();
    tick_100ms = 1; step();
    p0 = pulses;
    clear = 1; tick_100ms = 1; step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h300 || {running, warn, expired, expire_pulse} !== 4'b0 || pulses !== p0) begin
      errors++; $display("FAIL clear_run got %h flags %b want 300 0000", {sec_tens, sec_ones, tenths}, {running, warn, expired, expire_pulse});
    end
  endtask
  task automatic test_mid_reset();
    int p0;
    doLoad(8'h00, 4'h2);
    start = 1; step();
    tick_100ms = 1; step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h001 || running !== 1'b1) begin errors++; $display("FAIL pre_reset got %h run %b want 001 1", {sec_tens, sec_ones, tenths}, running); end
    p0 = pulses;
    rst = 0; tick_100ms = 1; step();
    rst = 1; step();
    checks++;
    if ({sec_tens, sec_ones, tenths} !== 12'h300 || {running, expired} !== 2'b00 || pulses !== p0) begin
      errors++; $display("FAIL mid_reset got %h run %b exp %b pulses %0d want 300 0 0 %0d", {sec_tens, sec_ones, tenths}, running, expired, pulses, p0);
    end
  endtask
  initial begin
    rst = 0; tick_100ms = 0; clear = 0; load = 0; start = 0; pause = 0;
    load_sec = 8'h00; load_tenths = 4'h0;
    test_reset();
    test_expire();
    test_borrow();
    test_pause();
    test_edges();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
